// File: rtl/axis_frame_player.sv
// AXI4-Stream frame player: beat memory, repeat/gap playback, abort, byte swap.
// Optional LFSR throttle between beats: define AXIS_FRAME_PLAYER_THROTTLE_EN.
module axis_frame_player #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [KEEP_W-1:0] i_wr_keep,
  input  logic              i_wr_last,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [CNT_W-1:0]  i_repeat,
  input  logic [CNT_W-1:0]  i_gap,
  input  logic              i_byte_swap,
  input  logic              i_abort,
  output logic              o_tx_axis_tvalid,
  input  logic              o_tx_axis_tready,
  output logic [DATA_W-1:0] o_tx_axis_tdata,
  output logic [KEEP_W-1:0] o_tx_axis_tkeep,
  output logic              o_tx_axis_tlast,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_frame_cnt
);

  localparam int ENT_W = DATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   sa_q, sa_d;
  logic [CNT_W-1:0]    rep_q, rep_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0]    gcnt_q, gcnt_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic                swap_q, swap_d;
  logic                abort_q, abort_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [KEEP_W-1:0]   keep_q, keep_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    ent_next, ent_start, ent_cur, ld_ent;
  logic [ADDR_W-1:0]   src_addr;
  logic                ld_next, ld_start, ld_cur;
  logic                swp, hs, bubble;

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < KEEP_W; k++)
      r[8*k +: 8] = d[8*(KEEP_W-1-k) +: 8];
    return r;
  endfunction

  // Memory is deliberately not reset; only IDLE writes land.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && state_q == IDLE)
      mem[i_wr_addr] <= {i_wr_last, i_wr_keep, i_wr_data};
  end

  assign src_addr  = (state_q == IDLE) ? i_start_addr : sa_q;
  assign ent_next  = mem[addr_q + ADDR_W'(1)];
  assign ent_start = mem[src_addr];
  assign ent_cur   = mem[addr_q];
  assign swp       = (state_q == IDLE) ? i_byte_swap : swap_q;
  assign hs        = valid_q & o_tx_axis_tready;

`ifdef AXIS_FRAME_PLAYER_THROTTLE_EN
  logic [15:0] lfsr;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign bubble = lfsr[0];
`else
  assign bubble = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sa_d     = sa_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    fcnt_d   = fcnt_q;
    swap_d   = swap_q;
    abort_d  = abort_q | ((state_q != IDLE) & i_abort);
    valid_d  = valid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    done_d   = 1'b0;
    ld_next  = 1'b0;
    ld_start = 1'b0;
    ld_cur   = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (i_start) begin
          sa_d    = i_start_addr;
          addr_d  = i_start_addr;
          rep_d   = i_repeat;
          gap_d   = i_gap;
          swap_d  = i_byte_swap;
          fcnt_d  = '0;
          state_d = PLAY;
          if (bubble) valid_d = 1'b0;
          else ld_start = 1'b1;
        end
      end
      PLAY: begin
        if (!valid_q) begin
          ld_cur = 1'b1;
        end else if (hs && !last_q) begin
          addr_d = addr_q + ADDR_W'(1);
          if (bubble) valid_d = 1'b0;
          else ld_next = 1'b1;
        end else if (hs) begin
          fcnt_d = fcnt_q + CNT_W'(1);
          if (rep_q != '0 && !abort_d) begin
            rep_d  = rep_q - CNT_W'(1);
            addr_d = sa_q;
            if (gap_q != '0) begin
              state_d = GAP;
              gcnt_d  = gap_q - CNT_W'(1);
              valid_d = 1'b0;
            end else if (bubble) begin
              valid_d = 1'b0;
            end else begin
              ld_start = 1'b1;
            end
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (abort_d) begin
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = IDLE;
        end else if (gcnt_q == '0) begin
          state_d = PLAY;
          if (bubble) valid_d = 1'b0;
          else ld_start = 1'b1;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ld_ent = ld_next ? ent_next : (ld_start ? ent_start : ent_cur);
    if (ld_next || ld_start || ld_cur) begin
      valid_d = 1'b1;
      data_d  = swp ? rev(ld_ent[DATA_W-1:0]) : ld_ent[DATA_W-1:0];
      keep_d  = ld_ent[DATA_W +: KEEP_W];
      last_d  = ld_ent[ENT_W-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sa_q    <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      fcnt_q  <= '0;
      swap_q  <= 1'b0;
      abort_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sa_q    <= sa_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      fcnt_q  <= fcnt_d;
      swap_q  <= swap_d;
      abort_q <= abort_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_axis_tvalid = valid_q;
  assign o_tx_axis_tdata  = data_q;
  assign o_tx_axis_tkeep  = keep_q;
  assign o_tx_axis_tlast  = last_q;
  assign o_busy           = (state_q != IDLE);
  assign o_done           = done_q;
  assign o_frame_cnt      = fcnt_q;

endmodule

// File: tb/tb_axis_frame_player.sv
// Directed bench for axis_frame_player: ARP frame playback, stalls,
// repeat/gap, abort, write-while-busy and mid-frame reset.
module tb_axis_frame_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_keep;
  logic        wr_last;
  logic        start;
  logic [5:0]  start_addr;
  logic [15:0] rep;
  logic [15:0] gap;
  logic        swap;
  logic        abort;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [15:0] fcnt;

  int nvec = 0;
  int nmis = 0;

  logic [63:0] raw [6] = '{64'h211abcdef11240b0, 64'h0102030405060708,
                           64'h1112131415161718, 64'h2122232425262728,
                           64'h3132333435363738, 64'h0186000000000000};
  logic [63:0] sw  [6] = '{64'hb04012f1debc1a21, 64'h0807060504030201,
                           64'h1817161514131211, 64'h2827262524232221,
                           64'h3837363534333231, 64'h0000000000008601};
  logic [7:0]  kp  [6] = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h03};
  logic        lst [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic        lv [64];
  logic        lr [64];
  logic        ll [64];
  logic        ld [64];
  logic        lb [64];
  logic [63:0] lt [64];
  logic [7:0]  lk [64];
  logic [15:0] lf [64];
  int          ncyc;
  int          done_idx;

  always #5 clk = ~clk;

  axis_frame_player dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_wr_en          (wr_en),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .i_wr_keep        (wr_keep),
    .i_wr_last        (wr_last),
    .i_start          (start),
    .i_start_addr     (start_addr),
    .i_repeat         (rep),
    .i_gap            (gap),
    .i_byte_swap      (swap),
    .i_abort          (abort),
    .o_tx_axis_tvalid (tvalid),
    .o_tx_axis_tready (tready),
    .o_tx_axis_tdata  (tdata),
    .o_tx_axis_tkeep  (tkeep),
    .o_tx_axis_tlast  (tlast),
    .o_busy           (busy),
    .o_done           (done),
    .o_frame_cnt      (fcnt)
  );

  task automatic load_frame();
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_addr = 6'(k); wr_data = raw[k];
      wr_keep = kp[k]; wr_last = lst[k];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Starts playback and logs one sample per cycle until o_done or budget.
  task automatic play(input logic [15:0] r, input logic [15:0] g,
                      input logic s, input int stall_at, input int stall_len,
                      input int abort_at, input int wr_at);
    @(posedge clk); #1;
    start_addr = '0; rep = r; gap = g; swap = s;
    start = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_idx = -1;
    ncyc = 0;
    for (int c = 0; c < 64; c++) begin
      tready = !(c >= stall_at && c < stall_at + stall_len);
      abort = (c == abort_at);
      wr_en = (c == wr_at);
      wr_addr = 6'd2; wr_data = 64'hdeadbeefdeadbeef;
      wr_keep = 8'h0f; wr_last = 1'b1;
      @(negedge clk);
      lv[c] = tvalid; lr[c] = tready; lt[c] = tdata; lk[c] = tkeep;
      ll[c] = tlast; ld[c] = done; lb[c] = busy; lf[c] = fcnt;
      ncyc = c + 1;
      @(posedge clk); #1;
      if (ld[c]) begin
        done_idx = c;
        break;
      end
    end
    tready = 1'b1; abort = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic test_reset();
    nvec++; if (tvalid !== 1'b0) begin nmis++;
      $display("FAIL reset_tvalid got %0b want 0", tvalid); end
    nvec++; if (busy !== 1'b0) begin nmis++;
      $display("FAIL reset_busy got %0b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nmis++;
      $display("FAIL reset_done got %0b want 0", done); end
    nvec++; if (fcnt !== 16'd0) begin nmis++;
      $display("FAIL reset_fcnt got %0d want 0", fcnt); end
    nvec++; if ({tdata, tkeep, tlast} !== 73'd0) begin nmis++;
      $display("FAIL reset_outputs got %h want 0", {tdata, tkeep, tlast}); end
  endtask

  task automatic test_arp();
    play(16'd0, 16'd0, 1'b1, -1, 0, -1, -1);
    nvec++; if (lt[0] !== 64'hb04012f1debc1a21 || lv[0] !== 1'b1) begin nmis++;
      $display("FAIL arp_first v=%0b d=%h want 1 b04012f1debc1a21", lv[0], lt[0]); end
    for (int k = 0; k < 6; k++) begin
      nvec++;
      if ({lv[k], lr[k], lt[k], lk[k], ll[k]} !== {2'b11, sw[k], kp[k], lst[k]}) begin
        nmis++;
        $display("FAIL arp_beat%0d v=%0b d=%h k=%h l=%0b want 1 %h %h %0b",
                 k, lv[k], lt[k], lk[k], ll[k], sw[k], kp[k], lst[k]);
      end
    end
    nvec++; if (lt[5] !== 64'h0000000000008601) begin nmis++;
      $display("FAIL arp_last_data got %h want 0000000000008601", lt[5]); end
    nvec++; if (done_idx !== 6) begin nmis++;
      $display("FAIL arp_done_idx got %0d want 6", done_idx); end
    nvec++; if (lf[6] !== 16'd1 || lb[6] !== 1'b0) begin nmis++;
      $display("FAIL arp_end fcnt=%0d busy=%0b want 1 0", lf[6], lb[6]); end
    @(negedge clk);
    nvec++; if (done !== 1'b0) begin nmis++;
      $display("FAIL arp_done_width got %0b want 0", done); end
  endtask

  task automatic test_backpressure();
    int nhs;
    play(16'd0, 16'd0, 1'b1, 2, 3, -1, -1);
    for (int c = 2; c < 6; c++) begin
      nvec++;
      if ({lv[c], lt[c], lk[c], ll[c]} !== {1'b1, sw[2], kp[2], lst[2]}) begin
        nmis++;
        $display("FAIL stall_hold c%0d v=%0b d=%h want 1 %h", c, lv[c], lt[c], sw[2]);
      end
    end
    nhs = 0;
    for (int c = 0; c < ncyc; c++) if (lv[c] && lr[c]) nhs++;
    nvec++; if (nhs !== 6) begin nmis++;
      $display("FAIL stall_beats got %0d want 6", nhs); end
    nvec++; if (done_idx !== 9) begin nmis++;
      $display("FAIL stall_done_idx got %0d want 9", done_idx); end
  endtask

  task automatic test_repeat_gap();
    logic ev;
    play(16'd2, 16'd4, 1'b0, -1, 0, -1, -1);
    for (int c = 0; c < 26; c++) begin
      ev = (c % 10) < 6;
      nvec++;
      if (lv[c] !== ev || (ev && lt[c] !== raw[c % 10])) begin
        nmis++;
        $display("FAIL gap_c%0d v=%0b d=%h want %0b %h", c, lv[c], lt[c], ev, raw[c % 10 % 6]);
      end
    end
    nvec++; if (lf[6] !== 16'd1) begin nmis++;
      $display("FAIL gap_fcnt_mid got %0d want 1", lf[6]); end
    nvec++; if (done_idx !== 26 || lf[26] !== 16'd3) begin nmis++;
      $display("FAIL gap_end idx=%0d fcnt=%0d want 26 3", done_idx, lf[26]); end
  endtask

  task automatic test_back_to_back();
    play(16'd1, 16'd0, 1'b0, -1, 0, -1, -1);
    for (int c = 0; c < 12; c++) begin
      nvec++;
      if (lv[c] !== 1'b1 || lt[c] !== raw[c % 6]) begin
        nmis++;
        $display("FAIL b2b_c%0d v=%0b d=%h want 1 %h", c, lv[c], lt[c], raw[c % 6]);
      end
    end
    nvec++; if (done_idx !== 12 || lf[12] !== 16'd2) begin nmis++;
      $display("FAIL b2b_end idx=%0d fcnt=%0d want 12 2", done_idx, lf[12]); end
  endtask

  task automatic test_abort_play();
    int nhs;
    play(16'd5, 16'd2, 1'b0, -1, 0, 2, -1);
    nhs = 0;
    for (int c = 0; c < ncyc; c++) if (lv[c] && lr[c]) nhs++;
    nvec++; if (nhs !== 6) begin nmis++;
      $display("FAIL abort_play_beats got %0d want 6", nhs); end
    nvec++; if (done_idx !== 6 || lf[6] !== 16'd1) begin nmis++;
      $display("FAIL abort_play_end idx=%0d fcnt=%0d want 6 1", done_idx, lf[6]); end
  endtask

  task automatic test_abort_gap();
    play(16'd5, 16'd4, 1'b0, -1, 0, 7, -1);
    nvec++; if (lv[6] !== 1'b0 || lv[7] !== 1'b0) begin nmis++;
      $display("FAIL abort_gap_valid got %0b%0b want 00", lv[6], lv[7]); end
    nvec++; if (done_idx !== 8) begin nmis++;
      $display("FAIL abort_gap_done_idx got %0d want 8", done_idx); end
    nvec++; if (lf[8] !== 16'd1 || lb[8] !== 1'b0) begin nmis++;
      $display("FAIL abort_gap_end fcnt=%0d busy=%0b want 1 0", lf[8], lb[8]); end
  endtask

  task automatic test_write_busy();
    play(16'd0, 16'd0, 1'b0, -1, 0, -1, 3);
    nvec++; if (done_idx !== 6) begin nmis++;
      $display("FAIL wbusy_first_done got %0d want 6", done_idx); end
    play(16'd0, 16'd0, 1'b0, -1, 0, -1, -1);
    nvec++;
    if (lt[2] !== raw[2] || lk[2] !== kp[2] || ll[2] !== lst[2] || done_idx !== 6) begin
      nmis++;
      $display("FAIL wbusy_replay d=%h k=%h l=%0b idx=%0d want %h ff 0 6",
               lt[2], lk[2], ll[2], done_idx, raw[2]);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start_addr = '0; rep = 16'd0; gap = 16'd0; swap = 1'b0;
    start = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    nvec++; if (tvalid !== 1'b1 || tdata !== raw[3]) begin nmis++;
      $display("FAIL rmid_pre v=%0b d=%h want 1 %h", tvalid, tdata, raw[3]); end
    rst = 1'b1;
    #1;
    nvec++; if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin nmis++;
      $display("FAIL rmid_async v=%0b b=%0b d=%0b want 0 0 0", tvalid, busy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    play(16'd0, 16'd0, 1'b0, -1, 0, -1, -1);
    nvec++; if (lt[0] !== raw[0] || lv[0] !== 1'b1 || done_idx !== 6) begin nmis++;
      $display("FAIL rmid_replay d=%h v=%0b idx=%0d want %h 1 6", lt[0], lv[0], done_idx, raw[0]); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_keep = '0;
    wr_last = 1'b0; start = 1'b0; start_addr = '0; rep = '0; gap = '0;
    swap = 1'b0; abort = 1'b0; tready = 1'b1;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    load_frame();
    test_arp();
    test_backpressure();
    test_repeat_gap();
    test_back_to_back();
    test_abort_play();
    test_abort_gap();
    test_write_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
